// File: rtl/ray_tracer_scheduler_if.sv
// ray_tracer_scheduler_if: pixel request and result handshakes of the ray/triangle scheduler
interface ray_tracer_scheduler_if #(
    parameter int NUM_TRI = 4,
    parameter int TRI_W   = 2
);
    logic               pix_valid;
    logic               pix_ready;
    logic [9:0]         pix_col;
    logic [8:0]         pix_row;
    logic [NUM_TRI-1:0] tri_enable;
    logic               res_valid;
    logic               res_ready;
    logic               res_hit;
    logic [TRI_W-1:0]   res_tri;
    logic [2:0]         res_z;

    modport master (
        output pix_valid, pix_col, pix_row, tri_enable, res_ready,
        input  pix_ready, res_valid, res_hit, res_tri, res_z
    );

    modport slave (
        input  pix_valid, pix_col, pix_row, tri_enable, res_ready,
        output pix_ready, res_valid, res_hit, res_tri, res_z
    );
endinterface

// File: rtl/ray_tracer_scheduler.sv
// ray_tracer_scheduler: scans the triangle slots for one pixel per request and returns the nearest hit
module ray_tracer_scheduler #(
    parameter int NUM_TRI = 4,
    parameter int TRI_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ray_tracer_scheduler_if.slave     bus,
    output logic [9:0]                core_pixel_col,
    output logic [8:0]                core_pixel_row,
    output logic [TRI_W-1:0]          core_tri_sel,
    input  logic                      core_rasterize,
    input  logic [2:0]                core_z
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [TRI_W-1:0]   idx;
    logic [9:0]         col_q;
    logic [8:0]         row_q;
    logic [NUM_TRI-1:0] mask_q;
    logic               best_hit;
    logic [TRI_W-1:0]   best_tri;
    logic [2:0]         best_z;
    logic               accept, last, take;

    assign accept = state == IDLE && bus.pix_valid;
    assign last   = idx == TRI_W'(NUM_TRI - 1);
    // strict less-than keeps the lower index on equal depth
    assign take   = state == SCAN && mask_q[idx] && core_rasterize && (!best_hit || core_z < best_z);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = bus.pix_valid ? SCAN : IDLE;
            SCAN:    state_nxt = last ? DONE : SCAN;
            DONE:    state_nxt = bus.res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mask_q   <= '0;
            best_hit <= 1'b0;
            best_tri <= '0;
            best_z   <= 3'd7;
        end else begin
            state <= state_nxt;
            if (accept) begin
                col_q    <= bus.pix_col;
                row_q    <= bus.pix_row;
                mask_q   <= bus.tri_enable;
                idx      <= '0;
                best_hit <= 1'b0;
                best_tri <= '0;
                best_z   <= 3'd7;
            end else if (state == SCAN) begin
                if (take) begin
                    best_hit <= 1'b1;
                    best_tri <= idx;
                    best_z   <= core_z;
                end
                if (!last) idx <= idx + 1'b1;
            end
        end
    end

    assign bus.pix_ready  = state == IDLE;
    assign bus.res_valid  = state == DONE;
    assign bus.res_hit    = best_hit;
    assign bus.res_tri    = best_tri;
    assign bus.res_z      = best_z;
    assign core_pixel_col = col_q;
    assign core_pixel_row = row_q;
    assign core_tri_sel   = state == SCAN ? idx : '0;
endmodule

// File: tb/tb_ray_tracer_scheduler.sv
// tb_ray_tracer_scheduler: directed checks of the scheduler against a table-driven core model
module tb_ray_tracer_scheduler;
    logic        clk;
    logic        rst_n;
    logic [9:0]  core_pixel_col;
    logic [8:0]  core_pixel_row;
    logic [1:0]  core_tri_sel;
    logic        core_rasterize;
    logic [2:0]  core_z;
    logic [3:0]  hit_v;
    logic [11:0] z_v;
    int          checks;
    int          failures;

    ray_tracer_scheduler_if #(.NUM_TRI(4), .TRI_W(2)) bus ();

    ray_tracer_scheduler #(.NUM_TRI(4), .TRI_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .core_pixel_col (core_pixel_col),
        .core_pixel_row (core_pixel_row),
        .core_tri_sel   (core_tri_sel),
        .core_rasterize (core_rasterize),
        .core_z         (core_z)
    );

    assign core_rasterize = hit_v[core_tri_sel];
    assign core_z         = z_v[core_tri_sel*3 +: 3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] c, input logic [8:0] r, input logic [3:0] m);
        bus.pix_col    = c;
        bus.pix_row    = r;
        bus.tri_enable = m;
        bus.pix_valid  = 1'b1;
        @(posedge clk); #1;
        bus.pix_valid  = 1'b0;
    endtask

    task automatic wait_res(input string tag, input logic hit, input logic [1:0] tri_i, input logic [2:0] z);
        int n;
        n = 1;
        while (!bus.res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_hit"}, bus.res_hit, hit);
        chk({tag, "_tri"}, bus.res_tri, tri_i);
        chk({tag, "_z"}, bus.res_z, z);
    endtask

    task automatic consume(input string tag);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk({tag, "_idle_rdy"}, bus.pix_ready, 1'b1);
        chk({tag, "_idle_vld"}, bus.res_valid, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_col = '0;
        bus.pix_row = '0;
        bus.tri_enable = '0;
        bus.res_ready = 1'b0;
        hit_v = '0;
        z_v = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", bus.pix_ready, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_z", bus.res_z, 3'd7);
        chk("rst_tri_sel", core_tri_sel, 2'd0);
        chk("rst_col", core_pixel_col, 10'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        hit_v = 4'b0100;
        z_v = {3'd0, 3'd5, 3'd0, 3'd0};
        send(10'd320, 9'd240, 4'b1111);
        chk("single_busy", bus.pix_ready, 1'b0);
        chk("single_col", core_pixel_col, 10'd320);
        chk("single_row", core_pixel_row, 9'd240);
        chk("single_sel0", core_tri_sel, 2'd0);
        wait_res("single", 1'b1, 2'd2, 3'd5);
        consume("single");

        hit_v = 4'b1111;
        z_v = {3'd4, 3'd3, 3'd3, 3'd6};
        send(10'd5, 9'd6, 4'b1111);
        wait_res("nearest", 1'b1, 2'd1, 3'd3);
        consume("nearest");
        send(10'd5, 9'd6, 4'b1101);
        wait_res("tie_mask", 1'b1, 2'd2, 3'd3);
        consume("tie_mask");

        send(10'd7, 9'd8, 4'b0000);
        wait_res("miss", 1'b0, 2'd0, 3'd7);
        consume("miss");

        send(10'd100, 9'd50, 4'b1111);
        wait_res("bp", 1'b1, 2'd1, 3'd3);
        for (int i = 0; i < 10; i++) begin
            bus.pix_col = 10'(i * 7);
            bus.tri_enable = 4'(i);
            bus.pix_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", bus.res_valid, 1'b1);
            chk("bp_ready", bus.pix_ready, 1'b0);
            chk("bp_tri", bus.res_tri, 2'd1);
            chk("bp_z", bus.res_z, 3'd3);
            chk("bp_col", core_pixel_col, 10'd100);
        end
        bus.pix_col = 10'd77;
        bus.pix_row = 9'd7;
        bus.tri_enable = 4'b1111;
        consume("bp");
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        chk("bp_accept_busy", bus.pix_ready, 1'b0);
        chk("bp_accept_col", core_pixel_col, 10'd77);
        wait_res("bp_next", 1'b1, 2'd1, 3'd3);
        consume("bp_next");

        hit_v = 4'b0001;
        z_v = {3'd0, 3'd0, 3'd0, 3'd1};
        send(10'd9, 9'd9, 4'b1111);
        @(posedge clk); #1;
        chk("mid_sel1", core_tri_sel, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.pix_ready, 1'b1);
        chk("mid_rst_valid", bus.res_valid, 1'b0);
        chk("mid_rst_hit", bus.res_hit, 1'b0);
        chk("mid_rst_z", bus.res_z, 3'd7);
        chk("mid_rst_sel", core_tri_sel, 2'd0);
        chk("mid_rst_col", core_pixel_col, 10'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hit_v = 4'b1000;
        z_v = {3'd6, 3'd0, 3'd0, 3'd0};
        send(10'd11, 9'd12, 4'b1111);
        wait_res("post_rst", 1'b1, 2'd3, 3'd6);
        consume("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
